// File: rtl/record_speak_pkg.sv
// Shared types and constants for the press-to-talk record/playback controller.
//   - state_e       : controller state encoding (exported on the state port)
//   - MIC_MID       : mid-scale code of the default 12-bit offset-binary sample
//   - LEVEL_*       : volume-meter mapping constants
//   - sample_mid()  : mid-scale code for an arbitrary sample width
//   - level_map()   : windowed peak amplitude -> bar count
package record_speak_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRecord = 2'd1,
    StPlay   = 2'd2
  } state_e;

  localparam int unsigned MIC_SAMPLE_W = 12;
  localparam int unsigned MIC_MID      = 1 << (MIC_SAMPLE_W - 1);

  localparam int unsigned LEVEL_DEADZONE = 64;
  localparam int unsigned LEVEL_SHIFT    = 7;
  localparam int unsigned LEVEL_MAX      = 16;

  function automatic int unsigned sample_mid(input int unsigned width);
    return 1 << (width - 1);
  endfunction

  // Peaks below the dead zone read as silence; otherwise one bar per 128 codes,
  // rounded up and capped at full scale.
  function automatic logic [4:0] level_map(input int unsigned peak);
    int unsigned bars;
    if (peak < LEVEL_DEADZONE) begin
      return 5'd0;
    end
    bars = (peak >> LEVEL_SHIFT) + 1;
    if (bars > LEVEL_MAX) begin
      bars = LEVEL_MAX;
    end
    return 5'(bars);
  endfunction

endpackage

// File: rtl/record_speak_ctrl_level_meter.sv
// Windowed peak volume meter.
// Ports:
//   clk        : system clock
//   reset      : synchronous active-high reset
//   in_valid   : strobe qualifying in_sample
//   in_sample  : unsigned offset-binary sample
//   level      : displayed bar count 0..16, updated the cycle after a window end
// Each window spans WINDOW strobes. The displayed level jumps up immediately to a
// louder window's value but falls back by only one bar per quieter window.
module level_meter
  import record_speak_pkg::*;
#(
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned WINDOW   = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [SAMPLE_W-1:0] in_sample,
  output logic [4:0]          level
);

  localparam int unsigned CntW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [CntW-1:0] WinLast = CntW'(WINDOW - 1);
  localparam logic [SAMPLE_W-1:0] Mid = SAMPLE_W'(sample_mid(SAMPLE_W));
  localparam logic [SAMPLE_W-2:0] AmpMax = '1;

  logic [CntW-1:0]     win_cnt_q, win_cnt_d;
  logic [SAMPLE_W-2:0] peak_q, peak_d;
  logic [4:0]          level_q, level_d;

  logic [SAMPLE_W-1:0] diff;
  logic [SAMPLE_W-2:0] amp;
  logic [SAMPLE_W-2:0] peak_max;
  logic [4:0]          new_level;

  always_comb begin
    // A sample of 0 is one code further from mid than full-scale positive;
    // clamp so the amplitude fits SAMPLE_W-1 bits.
    diff      = (in_sample >= Mid) ? (in_sample - Mid) : (Mid - in_sample);
    amp       = diff[SAMPLE_W-1] ? AmpMax : diff[SAMPLE_W-2:0];
    peak_max  = (amp > peak_q) ? amp : peak_q;
    new_level = level_map(32'(peak_max));

    win_cnt_d = win_cnt_q;
    peak_d    = peak_q;
    level_d   = level_q;

    if (in_valid) begin
      if (win_cnt_q == WinLast) begin
        win_cnt_d = '0;
        peak_d    = '0;
        // level_q == 0 always takes the first branch, so no underflow.
        level_d   = (new_level >= level_q) ? new_level : (level_q - 5'd1);
      end else begin
        win_cnt_d = win_cnt_q + 1'b1;
        peak_d    = peak_max;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q <= '0;
      peak_q    <= '0;
      level_q   <= '0;
    end else begin
      win_cnt_q <= win_cnt_d;
      peak_q    <= peak_d;
      level_q   <= level_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/record_speak_ctrl.sv
// Press-to-talk record/playback controller.
// Holding btn records mic samples into an external sample RAM; releasing it
// plays the recording back to the speaker path, then returns to idle.
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   sample_tick  : one-cycle sample-rate strobe
//   mic_in       : mic sample, valid with sample_tick
//   btn          : debounced talk button (level)
//   mem_we/mem_addr/mem_wdata : RAM write port (registered)
//   mem_rdata    : RAM read data for the currently presented mem_addr
//   spk_out      : speaker sample, mid-scale when not playing
//   spk_valid    : one-cycle strobe when spk_out updates
//   state        : 0 idle, 1 record, 2 play
//   level        : volume-meter bar count 0..16
module record_speak_ctrl
  import record_speak_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned SAMPLE_W = 12,
  parameter int unsigned WINDOW   = 2000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_tick,
  input  logic [SAMPLE_W-1:0] mic_in,
  input  logic                btn,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  input  logic [SAMPLE_W-1:0] mem_rdata,
  output logic [SAMPLE_W-1:0] spk_out,
  output logic                spk_valid,
  output logic [1:0]          state,
  output logic [4:0]          level
);

  localparam logic [SAMPLE_W-1:0] Mid = SAMPLE_W'(sample_mid(SAMPLE_W));
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};

  state_e              state_q, state_d;
  logic                btn_q;
  logic [ADDR_W:0]     wr_cnt_q, wr_cnt_d;
  logic [ADDR_W:0]     rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]     len_q, len_d;
  logic                rd_pend_q, rd_pend_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [SAMPLE_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [SAMPLE_W-1:0] spk_out_q, spk_out_d;
  logic                spk_valid_q, spk_valid_d;

  logic                press;
  logic                meter_valid;
  logic [SAMPLE_W-1:0] meter_sample;

  assign press = btn & ~btn_q;

  always_comb begin
    state_d     = state_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    len_d       = len_q;
    rd_pend_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    spk_out_d   = spk_out_q;
    spk_valid_d = 1'b0;

    case (state_q)
      StIdle: begin
        // A tick coinciding with the press is not recorded.
        if (press) begin
          wr_cnt_d = '0;
          state_d  = StRecord;
        end
      end

      StRecord: begin
        if (sample_tick) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = wr_cnt_q[ADDR_W-1:0];
          mem_wdata_d = mic_in;
          wr_cnt_d    = wr_cnt_q + 1'b1;
        end
        // wr_cnt_d already counts a write issued this cycle, so a release on
        // the same cycle as a tick keeps that sample.
        if (!btn || (wr_cnt_d == DepthCnt)) begin
          if (wr_cnt_d != '0) begin
            len_d    = wr_cnt_d;
            rd_cnt_d = '0;
            state_d  = StPlay;
          end else begin
            state_d = StIdle;
          end
        end
      end

      StPlay: begin
        if (sample_tick && (rd_cnt_q != len_q)) begin
          mem_addr_d = rd_cnt_q[ADDR_W-1:0];
          rd_cnt_d   = rd_cnt_q + 1'b1;
          rd_pend_d  = 1'b1;
        end
        if (rd_pend_q) begin
          spk_out_d   = mem_rdata;
          spk_valid_d = 1'b1;
        end
        // Last sample is on spk_out this cycle and nothing is in flight.
        if (spk_valid_q && !rd_pend_q && (rd_cnt_q == len_q)) begin
          spk_out_d = Mid;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      // Treat the button as already held so a press held across reset exit
      // does not start a recording.
      btn_q       <= 1'b1;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      len_q       <= '0;
      rd_pend_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      spk_out_q   <= Mid;
      spk_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      btn_q       <= btn;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      len_q       <= len_d;
      rd_pend_q   <= rd_pend_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      spk_out_q   <= spk_out_d;
      spk_valid_q <= spk_valid_d;
    end
  end

  // The meter follows the speaker during playback and the mic otherwise.
  assign meter_valid  = (state_q == StPlay) ? spk_valid_q : sample_tick;
  assign meter_sample = (state_q == StPlay) ? spk_out_q : mic_in;

  level_meter #(
    .SAMPLE_W (SAMPLE_W),
    .WINDOW   (WINDOW)
  ) u_level_meter (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (meter_valid),
    .in_sample (meter_sample),
    .level     (level)
  );

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign spk_out   = spk_out_q;
  assign spk_valid = spk_valid_q;
  assign state     = state_q;

endmodule

// File: tb/tb_record_speak_ctrl.sv
// Directed bench for record_speak_ctrl with a write/playback scoreboard.
module tb_record_speak_ctrl;

  localparam int unsigned AW    = 7;
  localparam int unsigned SW    = 12;
  localparam int unsigned WIN   = 4;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_tick = 1'b0;
  logic [SW-1:0] mic_in = '0;
  logic          btn = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_wdata;
  logic [SW-1:0] mem_rdata;
  logic [SW-1:0] spk_out;
  logic          spk_valid;
  logic [1:0]    state;
  logic [4:0]    level;

  record_speak_ctrl #(
    .ADDR_W   (AW),
    .SAMPLE_W (SW),
    .WINDOW   (WIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sample_tick (sample_tick),
    .mic_in      (mic_in),
    .btn         (btn),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .spk_out     (spk_out),
    .spk_valid   (spk_valid),
    .state       (state),
    .level       (level)
  );

  always #5 clk = ~clk;

  logic [SW-1:0] ram [DEPTH];
  always @(posedge clk) if (mem_we) ram[mem_addr] <= mem_wdata;
  assign mem_rdata = ram[mem_addr];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int n_we    = 0;
  int n_spk   = 0;

  logic [31:0]   wq[$];  // expected writes {addr, data}
  logic [SW-1:0] pq[$];  // expected speaker samples

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_we) begin
        n_we++;
        if (wq.size() == 0) begin
          check("extra_mem_we", 32'(mem_we), 32'd0);
        end else begin
          logic [31:0] e;
          e = wq.pop_front();
          check("mem_addr", 32'(mem_addr), 32'(e[SW+:AW]));
          check("mem_wdata", 32'(mem_wdata), 32'(e[SW-1:0]));
        end
      end
      if (spk_valid) begin
        n_spk++;
        if (pq.size() == 0) begin
          check("extra_spk_valid", 32'(spk_valid), 32'd0);
        end else begin
          logic [SW-1:0] e;
          e = pq.pop_front();
          check("spk_out", 32'(spk_out), 32'(e));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic [SW-1:0] d);
    mic_in      = d;
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    step(4);
  endtask

  task automatic rec_tick(input int idx, input logic [SW-1:0] d);
    wq.push_back(32'({AW'(idx), d}));
    pq.push_back(d);
    tick(d);
  endtask

  initial begin
    logic [SW-1:0] wd [7];
    int            wl [7];
    int            we0;
    int            sp0;

    wd = '{12'd2048, 12'd2048, 12'd2111, 12'd0, 12'd2112, 12'd1048, 12'd3048};
    wl = '{15, 14, 13, 16, 15, 14, 13};

    // Reset values
    step(2);
    reset = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_spk_out", 32'(spk_out), 32'd2048);
    check("rst_spk_valid", 32'(spk_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    step(1);

    // Level meter: window aligned to reset, mic source while idle
    repeat (3) tick(12'd4095);
    check("lvl_before_end", 32'(level), 32'd0);
    mic_in      = 12'd4095;
    sample_tick = 1'b1;
    #2;
    check("lvl_same_cycle", 32'(level), 32'd0);
    step(1);
    sample_tick = 1'b0;
    check("lvl_full", 32'(level), 32'd16);
    step(3);
    for (int w = 0; w < 7; w++) begin
      repeat (WIN) tick(wd[w]);
      check($sformatf("lvl_win%0d", w), 32'(level), 32'(wl[w]));
    end

    // Record 100 samples then play back
    pq.delete();
    btn = 1'b1;
    step(1);
    check("rec_enter", 32'(state), 32'd1);
    for (int i = 0; i < 100; i++) rec_tick(i, SW'(2548 + i * 3));
    btn = 1'b0;
    step(1);
    check("play_enter", 32'(state), 32'd2);
    n_spk = 0;
    mic_in      = 12'd2048;
    sample_tick = 1'b1;
    step(1);
    sample_tick = 1'b0;
    check("play_lat1", 32'(spk_valid), 32'd0);
    step(1);
    check("play_lat2", 32'(spk_valid), 32'd1);
    step(3);
    repeat (99) tick(12'd2048);
    check("rec_we_count", 32'(n_we), 32'd100);
    check("play_count", 32'(n_spk), 32'd100);
    check("play_queue_empty", 32'(pq.size()), 32'd0);
    check("play_done_state", 32'(state), 32'd0);
    check("play_done_spk", 32'(spk_out), 32'd2048);

    // Tap between ticks: no writes, no playback
    we0 = n_we;
    sp0 = n_spk;
    btn = 1'b1;
    step(1);
    check("tap_record", 32'(state), 32'd1);
    btn = 1'b0;
    step(1);
    check("tap_idle", 32'(state), 32'd0);
    repeat (3) tick(12'd3000);
    check("tap_no_we", 32'(n_we), 32'(we0));
    check("tap_no_spk", 32'(n_spk), 32'(sp0));
    check("tap_state", 32'(state), 32'd0);

    // Buffer full with btn held
    we0 = n_we;
    sp0 = n_spk;
    btn = 1'b1;
    step(1);
    for (int i = 0; i < int'(DEPTH); i++) rec_tick(i, SW'(i * 31 + 5));
    check("full_play_btn_held", 32'(state), 32'd2);
    repeat (DEPTH) tick(12'd2048);
    check("full_play_count", 32'(n_spk - sp0), 32'(DEPTH));
    check("full_idle", 32'(state), 32'd0);
    repeat (3) tick(12'd2048);
    check("full_no_rerecord", 32'(state), 32'd0);
    check("full_we_count", 32'(n_we - we0), 32'(DEPTH));
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    check("full_repress", 32'(state), 32'd1);
    btn = 1'b0;
    step(1);
    check("full_repress_idle", 32'(state), 32'd0);

    // Reset during playback at sample 5 of 20
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(2);
    btn = 1'b1;
    step(1);
    for (int i = 0; i < 20; i++) rec_tick(i, SW'(2648 + i));
    btn = 1'b0;
    step(1);
    repeat (5) tick(12'd2048);
    check("mid_play_level", 32'(level), 32'd5);
    reset = 1'b1;
    step(1);
    check("abort_state", 32'(state), 32'd0);
    check("abort_level", 32'(level), 32'd0);
    check("abort_spk_out", 32'(spk_out), 32'd2048);
    check("abort_spk_valid", 32'(spk_valid), 32'd0);
    reset = 1'b0;
    pq.delete();
    step(2);
    btn = 1'b1;
    step(1);
    check("abort_rerecord", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) rec_tick(i, SW'(100 + i * 500));
    btn = 1'b0;
    step(1);
    repeat (3) tick(12'd2048);
    check("abort_play_drained", 32'(pq.size()), 32'd0);
    check("abort_done", 32'(state), 32'd0);

    // Button held across reset exit
    btn   = 1'b1;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    step(3);
    check("held_reset_idle", 32'(state), 32'd0);
    we0 = n_we;
    tick(12'd1234);
    check("held_reset_no_we", 32'(n_we), 32'(we0));
    btn = 1'b0;
    step(1);
    btn = 1'b1;
    step(1);
    check("held_reset_press", 32'(state), 32'd1);
    btn = 1'b0;
    step(1);
    check("held_reset_release", 32'(state), 32'd0);

    check("write_queue_empty", 32'(wq.size()), 32'd0);
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/record_speak_ctrl.md
# record_speak_ctrl

Press-to-talk record/playback controller for the "Speak and Release" screen. Holding the talk button records microphone samples into an external sample RAM; releasing it plays the recording back to the speaker path. Throughout, the block computes a 0–16 bar volume level that drives the volume-meter renderer. It sits between the mic ADC front end, the sample BRAM, the speaker DAC path and the OLED screen renderer.

## Interface
Parameters:
- ADDR_W, 12, sample RAM address width; DEPTH = 2^ADDR_W samples.
- SAMPLE_W, 12, mic/speaker sample width, unsigned offset-binary, midpoint 2^(SAMPLE_W-1).
- WINDOW, 2000, number of sample_tick strobes per level-update window.

Ports:
- clk  in  1  system clock; one clock domain; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_tick  in  1  one-cycle sample-rate strobe (20 kHz).
- mic_in  in  SAMPLE_W  current mic sample, valid when sample_tick is high.
- btn  in  1  debounced talk button, level-sensitive.
- mem_we  out  1  RAM write enable, one-cycle pulse.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  SAMPLE_W  RAM write data.
- mem_rdata  in  SAMPLE_W  RAM read data, valid 1 cycle after the address is presented.
- spk_out  out  SAMPLE_W  speaker sample; holds the midpoint when not playing.
- spk_valid  out  1  one-cycle strobe when spk_out updates.
- state  out  2  0 IDLE, 1 RECORD, 2 PLAY.
- level  out  5  displayed bar count, 0..16.

## Operation
- The block keeps btn_q, a one-cycle delayed copy of btn. A press is btn & ~btn_q.
- **IDLE**
  - On a press: clear wr_addr to 0, then go to RECORD.
  - A button that is already held at reset exit does not start a recording. The button must be released and pressed again.
- **RECORD**
  - On each sample_tick: mem_we=1, mem_addr=wr_addr, mem_wdata=mic_in, then wr_addr++.
  - Exit on btn==0 or on buffer full:
    - If at least one sample was written: len = count written (ADDR_W+1 bits), rd_addr=0, go to PLAY.
    - If zero samples were written: go to IDLE.
  - Full means the sample at address DEPTH-1 was written. In that case len=DEPTH and the block goes to PLAY even if btn is still held.
- **PLAY**
  - On each sample_tick: present mem_addr=rd_addr, then rd_addr++.
  - The next cycle: spk_out=mem_rdata and spk_valid=1.
  - After the sample at rd_addr==len-1 has been output, spk_out returns to the midpoint and the block goes to IDLE.
  - btn is ignored in PLAY. A press during PLAY does not register; a new press after returning to IDLE is required.
- **Level meter**
  - Level source:
    - Outside PLAY: mic_in on sample_tick.
    - In PLAY: each spk_out on spk_valid.
  - amp = |sample − midpoint|, saturated to 2^(SAMPLE_W-1)−1.
  - peak = max(amp) over the window. Each window spans WINDOW strobes of the source in use.
  - At window end, compute new:
    - new = 0 if peak < 64 (dead zone);
    - otherwise new = min(16, (peak>>7)+1). For SAMPLE_W=12: 2047 → 16, 64 → 1.
  - Display update: if new ≥ level, level = new; otherwise level decrements by 1 (fall-back of one bar per window).
  - peak clears at every window end. The window counter free-runs and is not reset on state change.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_wdata=0, spk_out=midpoint, spk_valid=0, level=0. Internally, wr_addr=0, rd_addr=0, len=0, peak=0, window count=0.
- Reset mid-RECORD or mid-PLAY aborts the operation immediately. The recording is treated as lost.
- Record write latency: mem_we is asserted in the cycle after sample_tick.
- Playback latency: spk_valid rises 2 cycles after sample_tick (address register, then RAM read).
- sample_tick and btn release in the same RECORD cycle: the sample is written, and len includes it.
- sample_tick and a press in the same IDLE cycle: the first write happens on the next sample_tick, not this one.
- The RECORD→PLAY transition takes effect the cycle after the exit condition. The first playback read waits for the next sample_tick.
- level changes only in the cycle after a window end.

## Structure
- Shared package record_speak_pkg holds:
  - the state enum (IDLE/RECORD/PLAY, 2 bits);
  - MIC_MID;
  - LEVEL_DEADZONE=64, LEVEL_SHIFT=7, LEVEL_MAX=16.
- Sub-module level_meter contains the absolute value, windowed peak detector, level mapping and decay. Its ports: clk, reset, in_valid, in_sample, level.
- The top module holds the FSM, address counters and the RAM/speaker interface.

## Test plan
- Press btn for 100 ticks with mic_in=2048+500, then release:
  - exactly 100 mem_we pulses, addresses 0..99;
  - then 100 spk_valid pulses returning the same data;
  - state back to 0; spk_out=2048.
- Tap btn and release between two sample_ticks: no mem_we, state goes RECORD→IDLE, no playback.
- ADDR_W=4, btn held: 16 writes, then the block enters PLAY with btn still high and plays 16 samples. It returns to IDLE and does not re-record until btn is released and pressed again.
- Level: WINDOW=4, a window with peak amp 2047 gives level=16. Following windows with amp=0 give 15, 14, … one step per window. A window with amp=63 gives new=0, so level keeps decaying.
- Assert reset during PLAY at sample 5 of 20: the next cycle shows state=0, level=0, spk_out=2048, spk_valid=0. A following btn press records from address 0.
- btn already high when reset deasserts: stays in IDLE until btn goes low and then high.
